tpu_dot_seq: RTL and testbench

Operand sequencer and result collector placed directly upstream of the TPU minifloat MAC cell. It accepts a stream of 8-bit minifloat operand pairs, where each job is terminated by `in_last`. It drives the MAC's `input1`/`input2`/`reset`/`out_HL` pins so that exactly one dot product accumulates per job. It then reads both accumulator halves and returns a single 32-bit result beat with a sticky overflow flag and a beat count.

---
 rtl/tpu_dot_seq.sv | 155 +++++++++++++++
 tb/tb_tpu_dot_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_dot_seq.sv
// Operand sequencer / result collector for the TPU minifloat MAC cell: one dot product per job.
// Optional TPU_DOT_SEQ_ERR_ABORT_EN: once an overflow is seen, later pairs are counted but driven as zero.
module tpu_dot_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mac_reset,
  output logic [7:0]       mac_in1,
  output logic [7:0]       mac_in2,
  output logic             mac_out_HL,
  input  logic [15:0]      mac_out,
  input  logic             mac_error,
  output logic [31:0]      res_data,
  output logic             res_error,
  output logic [CNT_W-1:0] res_count,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_RD_HI,
    S_RD_LO,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             err, err_d;
  logic             accept;
  logic             abort;

  logic             in_ready_d, mac_reset_d, mac_hl_d;
  logic [7:0]       mac_in1_d, mac_in2_d;
  logic [31:0]      res_data_d;
  logic             res_error_d, res_valid_d;
  logic [CNT_W-1:0] res_count_d;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = in_valid && in_ready;
    case (state)
      S_IDLE:   if (accept) state_nx = in_last ? S_FLUSH : S_STREAM;
      S_STREAM: if (accept && in_last) state_nx = S_FLUSH;
      S_FLUSH:  state_nx = S_RD_HI;
      S_RD_HI:  state_nx = S_RD_LO;
      S_RD_LO:  state_nx = S_RESP;
      S_RESP:   if (res_valid && res_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the next state.
  always_comb begin
    in_ready_d  = (state_nx == S_IDLE) || (state_nx == S_STREAM);
    mac_reset_d = (state_nx == S_IDLE) || (state_nx == S_RESP);
    mac_in1_d   = '0;
    mac_in2_d   = '0;
    mac_hl_d    = mac_out_HL;
    res_data_d  = res_data;
    res_error_d = res_error;
    res_count_d = res_count;
    res_valid_d = res_valid;
    cnt_d       = cnt;
    err_d       = err;
`ifdef TPU_DOT_SEQ_ERR_ABORT_EN
    abort = (state == S_STREAM) && (err || mac_error);
`else
    abort = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          mac_in1_d = in_a;
          mac_in2_d = in_b;
          cnt_d     = CNT_ONE;
          err_d     = 1'b0;
        end
      end
      S_STREAM: begin
        err_d = err || mac_error;
        if (accept) begin
          if (!abort) begin
            mac_in1_d = in_a;
            mac_in2_d = in_b;
          end
          if (cnt != CNT_MAX) cnt_d = cnt + CNT_ONE;
        end
      end
      S_FLUSH: begin
        err_d    = err || mac_error;
        mac_hl_d = 1'b1;
      end
      S_RD_HI: begin
        res_data_d[31:16] = mac_out;
        mac_hl_d          = 1'b0;
      end
      S_RD_LO: begin
        res_data_d[15:0] = mac_out;
        res_error_d      = err;
        res_count_d      = cnt;
        res_valid_d      = 1'b1;
      end
      S_RESP: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      mac_reset  <= 1'b1;
      mac_in1    <= '0;
      mac_in2    <= '0;
      mac_out_HL <= 1'b0;
      res_data   <= '0;
      res_error  <= 1'b0;
      res_count  <= '0;
      res_valid  <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      mac_reset  <= mac_reset_d;
      mac_in1    <= mac_in1_d;
      mac_in2    <= mac_in2_d;
      mac_out_HL <= mac_hl_d;
      res_data   <= res_data_d;
      res_error  <= res_error_d;
      res_count  <= res_count_d;
      res_valid  <= res_valid_d;
      cnt        <= cnt_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_tpu_dot_seq.sv
// Self-checking bench for tpu_dot_seq with a behavioural MAC stand-in and a job-level reference model.
module tb_tpu_dot_seq;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_last, in_ready, mac_reset, mac_out_HL, mac_error;
  logic [7:0]    in_a, in_b, mac_in1, mac_in2;
  logic [15:0]   mac_out;
  logic [31:0]   res_data;
  logic          res_error, res_valid, res_ready;
  logic [CW-1:0] res_count;

  int n_vec = 0, n_fail = 0;

  always #5 clk = ~clk;

  tpu_dot_seq #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mac_reset(mac_reset), .mac_in1(mac_in1),
    .mac_in2(mac_in2), .mac_out_HL(mac_out_HL), .mac_out(mac_out), .mac_error(mac_error),
    .res_data(res_data), .res_error(res_error), .res_count(res_count),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  // Minifloat product as a signed 32-bit fixed-point value; overflow when the shift leaves 32 bits.
  function automatic int p_shift(input logic [7:0] a, input logic [7:0] b);
    return int'(a[6:3]) + int'(b[6:3]) - 2;
  endfunction
  function automatic bit p_ovf(input logic [7:0] a, input logic [7:0] b);
    return (a[6:3] != 4'd0) && (b[6:3] != 4'd0) && (p_shift(a, b) > 23);
  endfunction
  function automatic logic [31:0] p_val(input logic [7:0] a, input logic [7:0] b);
    logic [31:0] m;
    if (a[6:3] == 4'd0 || b[6:3] == 4'd0 || p_ovf(a, b)) return '0;
    m = (32'(8 + a[2:0]) * 32'(8 + b[2:0])) << p_shift(a, b);
    return (a[7] ^ b[7]) ? -m : m;
  endfunction

  // MAC cell stand-in
  logic [31:0] acc;
  always @(posedge clk) begin
    if (mac_reset) acc <= '0;
    else if (!p_ovf(mac_in1, mac_in2)) acc <= acc + p_val(mac_in1, mac_in2);
  end
  assign mac_out   = mac_out_HL ? acc[31:16] : acc[15:0];
  assign mac_error = p_ovf(mac_in1, mac_in2);

  logic [7:0]    ja[64], jb[64];
  int            jgap[64];
  int            jn;
  logic [31:0]   o_data;
  logic          o_err;
  logic [CW-1:0] o_cnt;
  int            o_lat, pres_bad;
  bit            to_flag;

  function automatic bit zeroed(input int k);
`ifdef TPU_DOT_SEQ_ERR_ABORT_EN
    for (int j = 0; j < k; j++) if (p_ovf(ja[j], jb[j])) return 1'b1;
`endif
    return 1'b0;
  endfunction
  function automatic bit job_has_ovf();
    for (int i = 0; i < jn; i++) if (p_ovf(ja[i], jb[i])) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] exp_data();
    logic [31:0] s = '0;
    for (int i = 0; i < jn; i++) if (!zeroed(i)) s += p_val(ja[i], jb[i]);
    return s;
  endfunction
  function automatic logic [CW-1:0] exp_cnt();
    return (jn > (2**CW - 1)) ? CW'(2**CW - 1) : CW'(jn);
  endfunction
  function automatic logic [7:0] rnd_op();
    logic [7:0] v = 8'($urandom);
    if (v[6] && $urandom_range(0, 9) != 0) v[6] = 1'b0;
    return v;
  endfunction

  task automatic setup_job(input int n, input logic [7:0] a, input logic [7:0] b);
    jn = n;
    for (int i = 0; i < 64; i++) begin ja[i] = a; jb[i] = b; jgap[i] = 0; end
  endtask

  // Streams ja/jb (with jgap idle cycles), tracks what must appear on mac_in, waits for the result.
  task automatic drive_job();
    int i = 0, g = 0, guard = 0;
    bit acc_now;
    logic [7:0] ea, eb;
    pres_bad = 0; to_flag = 0;
    while (i < jn && guard < 1000) begin
      if (g < jgap[i]) begin in_valid = 1'b0; in_last = 1'b0; end
      else begin in_valid = 1'b1; in_a = ja[i]; in_b = jb[i]; in_last = (i == jn - 1); end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1; guard++;
      if (acc_now) begin
        ea = zeroed(i) ? 8'h00 : ja[i];
        eb = zeroed(i) ? 8'h00 : jb[i];
        i++; g = 0;
      end else begin
        ea = 8'h00; eb = 8'h00;
        if (!in_valid) g++;
      end
      if (mac_in1 !== ea || mac_in2 !== eb) pres_bad++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    o_lat = 1;
    while (!res_valid && o_lat < 40) begin @(posedge clk); #1; o_lat++; end
    if (guard >= 1000 || !res_valid) to_flag = 1'b1;
    o_data = res_data; o_err = res_error; o_cnt = res_count;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (mac_reset !== 1'b1) begin n_fail++; $display("FAIL reset.mac_reset got=%b exp=1", mac_reset); end
    n_vec++; if ({mac_in1, mac_in2} !== 16'h0000) begin n_fail++; $display("FAIL reset.mac_in got=%h exp=0000", {mac_in1, mac_in2}); end
    n_vec++; if ({mac_out_HL, in_ready, res_valid, res_error} !== 4'b0000) begin n_fail++; $display("FAIL reset.flags got=%b exp=0000", {mac_out_HL, in_ready, res_valid, res_error}); end
    n_vec++; if ({res_data, res_count} !== '0) begin n_fail++; $display("FAIL reset.result got=%h/%0d exp=0/0", res_data, res_count); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset.idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    setup_job(3, 8'h08, 8'h08);
    drive_job();
    n_vec++; if (o_data !== 32'h000000C0) begin n_fail++; $display("FAIL basic.data got=%h exp=000000c0", o_data); end
    n_vec++; if (o_cnt !== CW'(3)) begin n_fail++; $display("FAIL basic.count got=%0d exp=3", o_cnt); end
    n_vec++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL basic.error got=%b exp=0", o_err); end
    n_vec++; if (pres_bad != 0 || to_flag) begin n_fail++; $display("FAIL basic.present got=%0d bad/timeout=%b exp=0/0", pres_bad, to_flag); end
    handshake();
  endtask

  task automatic test_single_latency();
    setup_job(1, 8'h88, 8'h08);
    drive_job();
    n_vec++; if (o_lat != 4) begin n_fail++; $display("FAIL single.latency got=%0d exp=4", o_lat); end
    n_vec++; if (o_data !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL single.data got=%h exp=ffffffc0", o_data); end
    n_vec++; if (o_cnt !== CW'(1)) begin n_fail++; $display("FAIL single.count got=%0d exp=1", o_cnt); end
    handshake();
  endtask

  task automatic test_gap();
    setup_job(4, 8'h08, 8'h08);
    jgap[2] = 2;
    drive_job();
    n_vec++; if (pres_bad != 0 || to_flag) begin n_fail++; $display("FAIL gap.present got=%0d bad/timeout=%b exp=0/0", pres_bad, to_flag); end
    n_vec++; if (o_data !== 32'h00000100) begin n_fail++; $display("FAIL gap.data got=%h exp=00000100", o_data); end
    n_vec++; if (o_cnt !== CW'(4)) begin n_fail++; $display("FAIL gap.count got=%0d exp=4", o_cnt); end
    handshake();
  endtask

  task automatic test_backpressure();
    setup_job(2, 8'h88, 8'h88);
    drive_job();
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (res_valid !== 1'b1 || res_data !== 32'h00000080 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL hold.c%0d got=v%b d%h r%b exp=v1 d00000080 r0", c, res_valid, res_data, in_ready); end
      @(posedge clk); #1;
    end
    handshake();
    n_vec++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL hold.idle got=r%b v%b exp=r1 v0", in_ready, res_valid); end
    setup_job(2, 8'h08, 8'h08);
    drive_job();
    n_vec++; if (o_data !== 32'h00000080) begin n_fail++; $display("FAIL hold.next_data got=%h exp=00000080", o_data); end
    handshake();
  endtask

  task automatic test_error();
    setup_job(2, 8'h08, 8'h08);
    ja[0] = 8'h78; jb[0] = 8'h78;
    drive_job();
    n_vec++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL error.flag got=%b exp=1", o_err); end
`ifdef TPU_DOT_SEQ_ERR_ABORT_EN
    n_vec++; if (o_data !== 32'h00000000) begin n_fail++; $display("FAIL error.data got=%h exp=00000000", o_data); end
`else
    n_vec++; if (o_data !== 32'h00000040) begin n_fail++; $display("FAIL error.data got=%h exp=00000040", o_data); end
`endif
    n_vec++; if (pres_bad != 0 || to_flag) begin n_fail++; $display("FAIL error.present got=%0d bad/timeout=%b exp=0/0", pres_bad, to_flag); end
    handshake();
    setup_job(1, 8'h08, 8'h08);
    drive_job();
    n_vec++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL error.cleared got=%b exp=0", o_err); end
    handshake();
  endtask

  task automatic test_saturation();
    setup_job(18, 8'h08, 8'h08);
    drive_job();
    n_vec++; if (o_cnt !== CW'(15)) begin n_fail++; $display("FAIL sat.count got=%0d exp=15", o_cnt); end
    n_vec++; if (o_data !== 32'h00000480) begin n_fail++; $display("FAIL sat.data got=%h exp=00000480", o_data); end
    handshake();
  endtask

  task automatic test_mid_reset();
    int k = 0, guard = 0;
    bit acc_now;
    in_valid = 1'b1; in_a = 8'h08; in_b = 8'h08; in_last = 1'b0;
    while (k < 2 && guard < 50) begin
      acc_now = in_ready;
      @(posedge clk); #1;
      if (acc_now) k++;
      guard++;
    end
    n_vec++; if (k != 2) begin n_fail++; $display("FAIL midrst.accepts got=%0d exp=2", k); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    n_vec++; if ({mac_reset, in_ready, mac_out_HL, res_valid, res_error} !== 5'b10000) begin n_fail++; $display("FAIL midrst.flags got=%b exp=10000", {mac_reset, in_ready, mac_out_HL, res_valid, res_error}); end
    n_vec++; if ({mac_in1, mac_in2, res_data, res_count} !== '0) begin n_fail++; $display("FAIL midrst.values got=%h %h %h %0d exp=0", mac_in1, mac_in2, res_data, res_count); end
    setup_job(1, 8'h08, 8'h08);
    drive_job();
    n_vec++; if (o_data !== 32'h00000040 || o_cnt !== CW'(1)) begin n_fail++; $display("FAIL midrst.job got=%h/%0d exp=00000040/1", o_data, o_cnt); end
    handshake();
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 30; j++) begin
      jn = $urandom_range(1, 17);
      for (int i = 0; i < jn; i++) begin
        ja[i] = rnd_op(); jb[i] = rnd_op();
        jgap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      drive_job();
      n_vec++; if (o_data !== exp_data()) begin n_fail++; $display("FAIL b2b%0d.data got=%h exp=%h", j, o_data, exp_data()); end
      n_vec++; if (o_err !== job_has_ovf() || o_cnt !== exp_cnt()) begin n_fail++; $display("FAIL b2b%0d.err_cnt got=%b/%0d exp=%b/%0d", j, o_err, o_cnt, job_has_ovf(), exp_cnt()); end
      n_vec++; if (pres_bad != 0 || to_flag || o_lat != 4) begin n_fail++; $display("FAIL b2b%0d.timing got=bad%0d to%b lat%0d exp=0/0/4", j, pres_bad, to_flag, o_lat); end
      handshake();
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d.turnaround got=%b exp=1", j, in_ready); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_single_latency();
    test_gap();
    test_backpressure();
    test_error();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
